// File: rtl/ai_i2s_tx_serializer.sv
// Philips-format I2S master transmitter draining a show-ahead stereo FIFO onto SCK/WS/SD.
// Build option AI_I2S_TX_REPEAT_ON_UNDERRUN_EN: an underrun frame replays the last frame (default: zeros).

module ai_i2s_tx_serializer #(
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned SLOT_WIDTH   = 16,
   parameter int unsigned SCK_DIV      = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [2*SAMPLE_WIDTH-1:0] fifo_rd_data,
   input  logic                      fifo_empty,
   output logic                      fifo_rd_en,
   output logic                      i2s_sck,
   output logic                      i2s_ws,
   output logic                      i2s_sd,
   output logic                      underrun,
   output logic                      busy
);

   localparam int unsigned FRAME_W    = 2 * SAMPLE_WIDTH;
   localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
   localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
   localparam int unsigned DIV_W      = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] SLOT_N    = CNT_W'(SLOT_WIDTH);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_WIDTH - 1);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_DIV - 1);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   bit_q, bit_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               sck_q, sck_d;
   logic               ws_q, ws_d;
   logic               sd_q, sd_d;
   logic               underrun_q, underrun_d;
   logic               busy_q, busy_d;
   logic               load_c;
   logic [FRAME_W-1:0] fill_c;

   // Serial bit k of a frame: MSB-first sample within its slot, zero padding past the sample.
   function automatic logic sd_bit(input logic [FRAME_W-1:0] frame, input logic [CNT_W-1:0] k);
      logic [CNT_W-1:0]        p;
      logic [SAMPLE_WIDTH-1:0] sample;
      logic [SAMPLE_WIDTH-1:0] sh;
      if (k < SLOT_N) begin
         p      = k;
         sample = frame[FRAME_W-1:SAMPLE_WIDTH];
      end else begin
         p      = k - SLOT_N;
         sample = frame[SAMPLE_WIDTH-1:0];
      end
      sh = sample << p;
      return (32'(p) < SAMPLE_WIDTH) ? sh[SAMPLE_WIDTH-1] : 1'b0;
   endfunction

   // WS leads data by one bit: it shows the channel of bit k+1.
   function automatic logic ws_bit(input logic [CNT_W-1:0] k);
      return (k >= SLOT_LAST) && (k != LAST_BIT);
   endfunction

`ifdef AI_I2S_TX_REPEAT_ON_UNDERRUN_EN
   assign fill_c = frame_q;
`else
   assign fill_c = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         frame_q    <= '0;
         sck_q      <= 1'b0;
         ws_q       <= 1'b0;
         sd_q       <= 1'b0;
         underrun_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         frame_q    <= frame_d;
         sck_q      <= sck_d;
         ws_q       <= ws_d;
         sd_q       <= sd_d;
         underrun_q <= underrun_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      frame_d    = frame_q;
      sck_d      = sck_q;
      ws_d       = ws_q;
      sd_d       = sd_q;
      underrun_d = 1'b0;
      load_c     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               load_c  = 1'b1;
               state_d = S_RUN;
               div_d   = '0;
               sck_d   = 1'b0;
               bit_d   = '0;
            end
         end
         S_RUN: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               sck_d = ~sck_q;
               // Falling SCK edge: advance to the next bit or close the frame.
               if (sck_q) begin
                  if (bit_q == LAST_BIT) begin
                     bit_d = '0;
                     if (enable) begin
                        load_c = 1'b1;
                     end else begin
                        state_d = S_IDLE;
                        sck_d   = 1'b0;
                        ws_d    = 1'b0;
                        sd_d    = 1'b0;
                     end
                  end else begin
                     bit_d = bit_q + CNT_W'(1);
                     sd_d  = sd_bit(frame_q, bit_d);
                     ws_d  = ws_bit(bit_d);
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load_c) begin
         underrun_d = fifo_empty;
         frame_d    = fifo_empty ? fill_c : fifo_rd_data;
         sd_d       = sd_bit(frame_d, CNT_W'(0));
         ws_d       = ws_bit(CNT_W'(0));
      end

      busy_d = (state_d == S_RUN);
   end

   // Gated by rst_n so a held reset with enable high never pops.
   assign fifo_rd_en = load_c & ~fifo_empty & rst_n;
   assign i2s_sck    = sck_q;
   assign i2s_ws     = ws_q;
   assign i2s_sd     = sd_q;
   assign underrun   = underrun_q;
   assign busy       = busy_q;

endmodule
